vertexinput_axil_cfg_initiator: RTL and testbench

VERTEXINPUT_AXIL_CFG_INITIATOR -- requirements
Module: vertexinput_axil_cfg_initiator

---
 rtl/vertexinput_axil_cfg_initiator_pkg.sv | 31 +++
 rtl/vertexinput_axil_cfg_initiator_if.sv | 48 ++++
 rtl/vertexinput_axil_cfg_initiator.sv | 181 ++++++++++++++++++
 tb/tb_vertexinput_axil_cfg_initiator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vertexinput_axil_cfg_initiator_pkg.sv
// Shared types and constants for the vertex-input AXI-lite configuration initiator.
// Bus widths default to 32 bits unless a project-wide define already set them.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

package vertexinput_axil_pkg;

   // Transaction sequencer states; one transaction in flight at most.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4,
      ST_RSP     = 3'd5
   } state_t;

   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_SLVERR  = 2'b10;
   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   // Registers are 32-bit words; anything not on a word boundary is refused.
   function automatic logic is_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/vertexinput_axil_cfg_initiator_if.sv
// AXI-lite bus bundle between the configuration initiator and its slave.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

interface vertexinput_axil_cfg_initiator_if #(
   parameter int ADDR_W = `ADDR_W,
   parameter int DATA_W = `DATA_W
) ();
   logic                awvalid;
   logic                awready;
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                wvalid;
   logic                wready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                bvalid;
   logic                bready;
   logic [1:0]          bresp;
   logic                arvalid;
   logic                arready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                rvalid;
   logic                rready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;

   modport master (
      output awvalid, awaddr, awprot, input awready,
      output wvalid, wdata, wstrb, input wready,
      input  bvalid, bresp, output bready,
      output arvalid, araddr, arprot, input arready,
      input  rvalid, rdata, rresp, output rready
   );

   modport slave (
      input  awvalid, awaddr, awprot, output awready,
      input  wvalid, wdata, wstrb, output wready,
      output bvalid, bresp, input bready,
      input  arvalid, araddr, arprot, output arready,
      output rvalid, rdata, rresp, input rready
   );
endinterface

// File: rtl/vertexinput_axil_cfg_initiator.sv
// AXI-lite configuration initiator: turns one command at a time into a single
// AXI-lite read or write and returns one response, with a per-transaction timeout.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

module vertexinput_axil_cfg_initiator
   import vertexinput_axil_pkg::*;
#(
   parameter int ADDR_W      = `ADDR_W,
   parameter int DATA_W      = `DATA_W,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_write,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic                rsp_timeout,
   vertexinput_axil_cfg_initiator_if.master axil
);

   localparam int               STRB_W   = DATA_W / 8;
   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [STRB_W-1:0]   r_wstrb;
   logic                r_aw_done;
   logic                r_w_done;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic [1:0]          r_rsp_resp;
   logic                r_rsp_timeout;

   logic w_cmd_acc, w_aligned, w_busy, w_tmo, w_tmo_fire;
   logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_aw_ok, w_w_ok;

   // Valids/readies decode from registered state only, never from the slave's readies.
   assign cmd_ready    = (r_state == ST_IDLE);
   assign axil.awvalid = (r_state == ST_WR_REQ) && !r_aw_done;
   assign axil.wvalid  = (r_state == ST_WR_REQ) && !r_w_done;
   assign axil.bready  = (r_state == ST_WR_RESP);
   assign axil.arvalid = (r_state == ST_RD_REQ);
   assign axil.rready  = (r_state == ST_RD_RESP);
   assign axil.awaddr  = r_addr;
   assign axil.araddr  = r_addr;
   assign axil.awprot  = PROT_DEFAULT;
   assign axil.arprot  = PROT_DEFAULT;
   assign axil.wdata   = r_wdata;
   assign axil.wstrb   = r_wstrb;

   assign rsp_valid   = (r_state == ST_RSP);
   assign rsp_write   = r_write;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_resp    = r_rsp_resp;
   assign rsp_timeout = r_rsp_timeout;

   assign w_cmd_acc = cmd_valid && cmd_ready;
   assign w_aligned = is_aligned(cmd_addr[1:0]);
   assign w_aw_hs   = axil.awvalid && axil.awready;
   assign w_w_hs    = axil.wvalid && axil.wready;
   assign w_b_hs    = axil.bvalid && axil.bready;
   assign w_ar_hs   = axil.arvalid && axil.arready;
   assign w_r_hs    = axil.rvalid && axil.rready;
   assign w_aw_ok   = r_aw_done || w_aw_hs;
   assign w_w_ok    = r_w_done || w_w_hs;
   assign w_busy    = (r_state == ST_WR_REQ) || (r_state == ST_WR_RESP) ||
                      (r_state == ST_RD_REQ) || (r_state == ST_RD_RESP);
   // A real handshake on the last allowed cycle still wins over the timeout.
   assign w_tmo      = w_busy && (r_cnt >= TMO_LAST);
   assign w_tmo_fire = w_tmo && (w_state_nxt == ST_RSP) && !w_b_hs && !w_r_hs;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!w_cmd_acc)      w_state_nxt = ST_IDLE;
            else if (!w_aligned) w_state_nxt = ST_RSP;
            else if (cmd_write)  w_state_nxt = ST_WR_REQ;
            else                 w_state_nxt = ST_RD_REQ;
         end
         ST_WR_REQ: begin
            if (w_aw_ok && w_w_ok) w_state_nxt = ST_WR_RESP;
            else if (w_tmo)        w_state_nxt = ST_RSP;
            else                   w_state_nxt = ST_WR_REQ;
         end
         ST_WR_RESP: begin
            if (w_b_hs || w_tmo) w_state_nxt = ST_RSP;
            else                 w_state_nxt = ST_WR_RESP;
         end
         ST_RD_REQ: begin
            if (w_ar_hs)    w_state_nxt = ST_RD_RESP;
            else if (w_tmo) w_state_nxt = ST_RSP;
            else            w_state_nxt = ST_RD_REQ;
         end
         ST_RD_RESP: begin
            if (w_r_hs || w_tmo) w_state_nxt = ST_RSP;
            else                 w_state_nxt = ST_RD_RESP;
         end
         ST_RSP: begin
            if (rsp_ready) w_state_nxt = ST_IDLE;
            else           w_state_nxt = ST_RSP;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Capture the command on acceptance and track which write channels have handshaken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_write   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if (w_cmd_acc) begin
         r_write   <= cmd_write;
         r_addr    <= cmd_addr;
         r_wdata   <= cmd_wdata;
         r_wstrb   <= cmd_wstrb;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs)  r_w_done  <= 1'b1;
      end
   end

   // Per-transaction cycle counter, restarted by each accepted command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_cnt <= '0;
      else if (w_cmd_acc) r_cnt <= '0;
      else if (w_busy)    r_cnt <= r_cnt + CNT_W'(1);
   end

   // Response fields: refusal, bus result or timeout; held until the next command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= RESP_OKAY;
         r_rsp_timeout <= 1'b0;
      end else if (w_cmd_acc) begin
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= w_aligned ? RESP_OKAY : RESP_SLVERR;
         r_rsp_timeout <= 1'b0;
      end else if (w_b_hs) begin
         r_rsp_resp    <= axil.bresp;
      end else if (w_r_hs) begin
         r_rsp_rdata   <= axil.rdata;
         r_rsp_resp    <= axil.rresp;
      end else if (w_tmo_fire) begin
         r_rsp_resp    <= RESP_SLVERR;
         r_rsp_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vertexinput_axil_cfg_initiator.sv
// Directed bench for the AXI-lite configuration initiator with a scoreboard of responses.
module tb_vertexinput_axil_cfg_initiator;

   localparam int TMO = 16;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        tmo;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   exp_t sb_q[$];

   // Slave knobs, driven from the stimulus block.
   int          aw_delay = 0, w_delay = 0, ar_delay = 0;
   bit          b_en = 1'b1, r_en = 1'b1;
   logic        b_force = 1'b0;
   logic [1:0]  b_resp_k = 2'b00, r_resp_k = 2'b00;
   logic [31:0] r_data_k = 32'h0;

   // Slave state and handshake counters.
   int          aw_seen, w_seen, ar_seen;
   logic        aw_got, w_got, bvalid_r, rvalid_r;
   logic [31:0] rdata_r;
   logic [1:0]  rresp_r;
   int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, vld_cyc = 0;

   vertexinput_axil_cfg_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   vertexinput_axil_cfg_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .axil(bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave readies: ready after the programmed number of valid cycles.
   assign bus.awready = bus.awvalid && (aw_seen >= aw_delay);
   assign bus.wready  = bus.wvalid && (w_seen >= w_delay);
   assign bus.arready = bus.arvalid && (ar_seen >= ar_delay);
   assign bus.bvalid  = bvalid_r | b_force;
   assign bus.bresp   = b_resp_k;
   assign bus.rvalid  = rvalid_r;
   assign bus.rdata   = rdata_r;
   assign bus.rresp   = rresp_r;

   // Slave protocol model: wait counters, B after both write beats, R one cycle after AR.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_seen <= 0; w_seen <= 0; ar_seen <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b0; rvalid_r <= 1'b0;
         rdata_r <= 32'h0; rresp_r <= 2'b00;
      end else begin
         if (bus.awvalid && bus.awready) aw_seen <= 0; else if (bus.awvalid) aw_seen <= aw_seen + 1;
         if (bus.wvalid && bus.wready)   w_seen  <= 0; else if (bus.wvalid)  w_seen  <= w_seen + 1;
         if (bus.arvalid && bus.arready) ar_seen <= 0; else if (bus.arvalid) ar_seen <= ar_seen + 1;
         if (bus.bvalid && bus.bready) bvalid_r <= 1'b0;
         if ((aw_got || (bus.awvalid && bus.awready)) && (w_got || (bus.wvalid && bus.wready))) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            if (b_en) bvalid_r <= 1'b1;
         end else begin
            if (bus.awvalid && bus.awready) aw_got <= 1'b1;
            if (bus.wvalid && bus.wready)   w_got  <= 1'b1;
         end
         if (bus.rvalid && bus.rready) rvalid_r <= 1'b0;
         if (bus.arvalid && bus.arready && r_en) begin
            rvalid_r <= 1'b1;
            rdata_r  <= r_data_k;
            rresp_r  <= r_resp_k;
         end
      end
   end

   // Handshake and valid-cycle counters, never cleared.
   always @(posedge clk) begin
      if (bus.awvalid && bus.awready) aw_cnt <= aw_cnt + 1;
      if (bus.wvalid && bus.wready)   w_cnt  <= w_cnt + 1;
      if (bus.bvalid && bus.bready)   b_cnt  <= b_cnt + 1;
      if (bus.arvalid && bus.arready) ar_cnt <= ar_cnt + 1;
      if (bus.awvalid || bus.arvalid) vld_cyc <= vld_cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input logic [31:0] e_rdata, input logic [1:0] e_resp,
                           input logic e_tmo, input bit push, output int acc, output int waited);
      exp_t e;
      logic al;
      al = (addr[1:0] == 2'b00);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
      waited = 0;
      while (!cmd_ready && waited < 50) begin
         tick();
         waited++;
      end
      chk("cmd_accept", 64'(cmd_ready), 64'd1);
      acc = cyc;
      if (push) begin
         e.wr = wr; e.addr = addr; e.wdata = wd; e.wstrb = st;
         e.rdata = e_rdata; e.resp = e_resp; e.tmo = e_tmo;
         sb_q.push_back(e);
      end
      tick();
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = $urandom; cmd_wstrb = 4'h0;
      chk("bus_lat_aw", 64'(bus.awvalid), 64'(wr & al));
      chk("bus_lat_w",  64'(bus.wvalid),  64'(wr & al));
      chk("bus_lat_ar", 64'(bus.arvalid), 64'(~wr & al));
   endtask

   task automatic wait_rsp(input string tag, input int acc, input int exp_lat, input int hold, input bit late_b);
      exp_t e;
      int   n;
      n = 0;
      while (!rsp_valid && n < 100) begin
         if (sb_q.size() > 0) begin
            if (bus.awvalid) chk({tag, "_aw"}, 64'({bus.awprot, bus.awaddr}), 64'({3'b000, sb_q[0].addr}));
            if (bus.wvalid)  chk({tag, "_w"},  64'({bus.wstrb, bus.wdata}), 64'({sb_q[0].wstrb, sb_q[0].wdata}));
            if (bus.arvalid) chk({tag, "_ar"}, 64'({bus.arprot, bus.araddr}), 64'({3'b000, sb_q[0].addr}));
         end
         tick();
         n++;
      end
      chk({tag, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
      if (exp_lat >= 0) chk({tag, "_lat"}, 64'(cyc - acc), 64'(exp_lat));
      chk({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = '{wr: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h0, resp: 2'b00, tmo: 1'b0};
      for (int i = 0; i < hold; i++) begin
         b_force = late_b;
         chk({tag, "_hold_ctl"}, 64'({rsp_valid, cmd_ready, rsp_write, rsp_timeout, rsp_resp}),
             64'({1'b1, 1'b0, e.wr, e.tmo, e.resp}));
         chk({tag, "_hold_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
         tick();
      end
      if (late_b) chk({tag, "_late_b_bready"}, 64'(bus.bready), 64'd0);
      chk({tag, "_write"},   64'(rsp_write),   64'(e.wr));
      chk({tag, "_rdata"},   64'(rsp_rdata),   64'(e.rdata));
      chk({tag, "_resp"},    64'(rsp_resp),    64'(e.resp));
      chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.tmo));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      b_force   = 1'b0;
      chk({tag, "_idle_after"}, 64'({cmd_ready, rsp_valid}), 64'b10);
   endtask

   initial begin
      int acc, wt, n;
      int s_aw, s_w, s_b, s_ar, s_v;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
      cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
      repeat (3) tick();

      // Reset state.
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_rsp", 64'({rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata}), 64'd0);
      chk("rst_bus_ctl", 64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.awprot, bus.arprot}), 64'd0);
      chk("rst_bus_data", 64'(bus.awaddr | bus.araddr | bus.wdata | {28'd0, bus.wstrb}), 64'd0);
      rst = 1'b0;
      tick();

      // Write with AW ready delayed three cycles, W immediate.
      aw_delay = 3;
      s_aw = aw_cnt; s_w = w_cnt; s_b = b_cnt;
      send_cmd(1'b1, 32'h0, 32'h0000_0003, 4'hF, 32'h0, 2'b00, 1'b0, 1'b1, acc, wt);
      wait_rsp("wr_awdly", acc, 6, 0, 1'b0);
      chk("wr_awdly_aw_hs", 64'(aw_cnt - s_aw), 64'd1);
      chk("wr_awdly_w_hs",  64'(w_cnt - s_w),   64'd1);
      chk("wr_awdly_b_hs",  64'(b_cnt - s_b),   64'd1);
      aw_delay = 0;

      // Zero-wait write with partial strobes and a slave error response.
      b_resp_k = 2'b10;
      send_cmd(1'b1, 32'h0000_000C, 32'hA5A5_5A5A, 4'h5, 32'h0, 2'b10, 1'b0, 1'b1, acc, wt);
      wait_rsp("wr_zw", acc, 3, 0, 1'b0);
      b_resp_k = 2'b00;

      // Zero-wait read.
      r_data_k = 32'hDEAD_BEEF; r_resp_k = 2'b00;
      s_ar = ar_cnt;
      send_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1, acc, wt);
      wait_rsp("rd_zw", acc, 3, 0, 1'b0);
      chk("rd_zw_ar_hs", 64'(ar_cnt - s_ar), 64'd1);

      // Read with AR delay and SLVERR data beat.
      ar_delay = 2; r_data_k = 32'h1234_5678; r_resp_k = 2'b10;
      send_cmd(1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'h1234_5678, 2'b10, 1'b0, 1'b1, acc, wt);
      wait_rsp("rd_ardly", acc, 5, 0, 1'b0);
      ar_delay = 0; r_resp_k = 2'b00;

      // Misaligned commands never reach the bus.
      s_v = vld_cyc;
      send_cmd(1'b1, 32'h0000_0002, 32'hFFFF_0000, 4'hF, 32'h0, 2'b10, 1'b0, 1'b1, acc, wt);
      wait_rsp("mis_wr", acc, 1, 0, 1'b0);
      send_cmd(1'b0, 32'h0000_0001, 32'h0, 4'h0, 32'h0, 2'b10, 1'b0, 1'b1, acc, wt);
      wait_rsp("mis_rd", acc, 1, 0, 1'b0);
      chk("mis_no_bus_valid", 64'(vld_cyc - s_v), 64'd0);

      // Write whose B never comes: timeout, held response, late B ignored.
      b_en = 1'b0;
      s_b = b_cnt;
      send_cmd(1'b1, 32'h0000_0010, 32'h0000_0055, 4'hF, 32'h0, 2'b10, 1'b1, 1'b1, acc, wt);
      wait_rsp("wr_tmo", acc, TMO + 1, 5, 1'b1);
      chk("wr_tmo_no_b_hs", 64'(b_cnt - s_b), 64'd0);
      b_en = 1'b1;

      // Next command proceeds normally.
      r_data_k = 32'hCAFE_F00D;
      send_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 1'b0, 1'b1, acc, wt);
      wait_rsp("rd_after_tmo", acc, 3, 0, 1'b0);

      // Reset while waiting for R: abandoned, then accepted right after release.
      r_en = 1'b0;
      send_cmd(1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 2'b00, 1'b0, 1'b0, acc, wt);
      n = 0;
      while (!bus.rready && n < 20) begin
         tick();
         n++;
      end
      chk("rst_mid_reach_rd_resp", 64'(bus.rready), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_async", 64'({bus.arvalid, bus.rready, rsp_valid, cmd_ready}), 64'b0001);
      tick();
      tick();
      rst = 1'b0;
      r_en = 1'b1; r_data_k = 32'h0BAD_F00D;
      send_cmd(1'b0, 32'h0000_0024, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 1'b0, 1'b1, acc, wt);
      chk("post_rst_accept_wait", 64'(wt), 64'd0);
      wait_rsp("rd_post_rst", acc, 3, 0, 1'b0);

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // Absolute time bound in case a wait above is mis-sized.
   initial begin
      #500000;
      $display("FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
